// File: rtl/dmx_pkg.sv
// DMX512 frame-controller shared types, constants and timing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmx_pkg;

  // Line/frame sequencing states shared by the controller and the break detector
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_BREAK    = 3'd1,
    ST_MAB      = 3'd2,
    ST_RX_START = 3'd3,
    ST_RX_SLOTS = 3'd4
  } dmx_state_t;

  localparam int         DMX_MAX_SLOTS      = 512;
  localparam logic [7:0] DMX_STD_START_CODE = 8'h00;

  // Convert a duration in microseconds into system clock cycles
  function automatic int us_to_clks(input int clk_freq, input int us);
    longint prod;
    prod = longint'(clk_freq) * longint'(us);
    return int'(prod / 64'sd1000000);
  endfunction

endpackage

// File: rtl/dmx_break_detector.sv
// Detects a DMX BREAK followed by MAB on the raw line and emits a one-cycle arm pulse.
// Latency: arm is combinational, asserted in the cycle the line falls at the end of MAB.
// Backpressure: none; en low holds the detector idle while a frame is being received.
module dmx_break_detector
  import dmx_pkg::*;
#(
  parameter int BREAK_CLKS = 1760,
  parameter int MAB_CLKS   = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic line,
  output logic arm
);

  localparam logic [15:0] BREAK_T = 16'(BREAK_CLKS);
  localparam logic [15:0] MAB_T   = 16'(MAB_CLKS);

  dmx_state_t  state_q, state_d;
  logic [15:0] timer_q, timer_d;

  // Next-state: time the low (BREAK) and high (MAB) phases; timer saturates
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    arm     = 1'b0;
    if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!line) state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (line) begin
          timer_d = '0;
          state_d = (timer_q >= BREAK_T) ? ST_MAB : ST_IDLE;
        end
      end
      ST_MAB: begin
        if (!line) begin
          timer_d = '0;
          if (timer_q >= MAB_T) begin
            arm     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BREAK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      timer_d = '0;
      arm     = 1'b0;
    end
  end

  // State and timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/dmx_frame_controller.sv
// Sequences a DMX512 byte receiver over a frame and writes matching slots to slot RAM.
// Latency: slot_we/frame pulses are registered, one cycle after the byte_ready rising edge.
// Backpressure: none; the receiver handshake is edge-detected and the RAM always accepts.
module dmx_frame_controller
  import dmx_pkg::*;
#(
  parameter int         CLK_FREQ        = 20_000_000,
  parameter int         BREAK_MIN_US    = 88,
  parameter int         MAB_MIN_US      = 8,
  parameter int         SLOT_TIMEOUT_US = 100,
  parameter logic [7:0] START_CODE      = DMX_STD_START_CODE,
  parameter int         MAX_SLOTS       = DMX_MAX_SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DMX_Input_Signal,
  input  logic       byte_ready,
  input  logic [7:0] received_byte,
  input  logic       error,
  input  logic       byte_done,
  output logic       start_receive,
  output logic       slot_we,
  output logic [8:0] slot_addr,
  output logic [7:0] slot_data,
  output logic [7:0] start_code_out,
  output logic [9:0] slot_count,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       overflow
);

  localparam int          BREAK_CLKS = us_to_clks(CLK_FREQ, BREAK_MIN_US);
  localparam int          MAB_CLKS   = us_to_clks(CLK_FREQ, MAB_MIN_US);
  localparam logic [15:0] SLOT_TO    = 16'(us_to_clks(CLK_FREQ, SLOT_TIMEOUT_US));
  localparam logic [9:0]  MAX_L      = 10'(MAX_SLOTS);

  dmx_state_t  state_q, state_d;
  logic        byte_ready_q, error_q;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  start_code_q, start_code_d;
  logic [9:0]  slot_count_q, slot_count_d;
  logic        slot_we_q, slot_we_d;
  logic [8:0]  slot_addr_q, slot_addr_d;
  logic [7:0]  slot_data_q, slot_data_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        overflow_q, overflow_d;
  logic        arm, br_rise, err_rise, gap_expired;
  logic [9:0]  new_slot;

  // The break detector only listens while no frame is being received
  dmx_break_detector #(
    .BREAK_CLKS(BREAK_CLKS),
    .MAB_CLKS  (MAB_CLKS)
  ) u_break (
    .clk (clk),
    .rst (rst),
    .en  (state_q == ST_IDLE),
    .line(DMX_Input_Signal),
    .arm (arm)
  );

  assign br_rise     = byte_ready & ~byte_ready_q;
  assign err_rise    = error & ~error_q;
  assign gap_expired = (gap_q == SLOT_TO);
  assign new_slot    = (slot_count_q == 10'h3FF) ? slot_count_q : slot_count_q + 10'd1;

  // Frame sequencing; an error edge beats a same-cycle byte, and a byte beats byte_done
  always_comb begin
    state_d       = state_q;
    gap_d         = (gap_q == 16'hFFFF) ? gap_q : gap_q + 16'd1;
    start_code_d  = start_code_q;
    slot_count_d  = slot_count_q;
    slot_we_d     = 1'b0;
    slot_addr_d   = slot_addr_q;
    slot_data_d   = slot_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    overflow_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (arm) begin
          state_d      = ST_RX_START;
          slot_count_d = '0;
        end
      end
      ST_RX_START, ST_RX_SLOTS: begin
        if (err_rise || gap_expired) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          if (br_rise) begin
            gap_d = '0;
            if (state_q == ST_RX_START) begin
              start_code_d = received_byte;
              state_d      = ST_RX_SLOTS;
            end else begin
              slot_count_d = new_slot;
              if (new_slot > MAX_L) begin
                overflow_d = 1'b1;
              end else if (start_code_q == START_CODE) begin
                slot_we_d   = 1'b1;
                slot_addr_d = new_slot[8:0] - 9'd1;
                slot_data_d = received_byte;
              end
            end
          end
          if (byte_done) begin
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registers: edge-detect history, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_ready_q  <= 1'b0;
      error_q       <= 1'b0;
      gap_q         <= '0;
      start_code_q  <= '0;
      slot_count_q  <= '0;
      slot_we_q     <= 1'b0;
      slot_addr_q   <= '0;
      slot_data_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_ready_q  <= byte_ready;
      error_q       <= error;
      gap_q         <= gap_d;
      start_code_q  <= start_code_d;
      slot_count_q  <= slot_count_d;
      slot_we_q     <= slot_we_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign start_receive  = arm;
  assign slot_we        = slot_we_q;
  assign slot_addr      = slot_addr_q;
  assign slot_data      = slot_data_q;
  assign start_code_out = start_code_q;
  assign slot_count     = slot_count_q;
  assign frame_valid    = frame_valid_q;
  assign frame_error    = frame_error_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_dmx_frame_controller.sv
// Directed self-checking bench for dmx_frame_controller at 20 MHz.
// Latency: checks registered outputs on the falling edge.
// Backpressure: n/a; receiver handshake driven directly.
`timescale 1ns/1ps
module tb_dmx_frame_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       line;
  logic       byte_ready;
  logic [7:0] received_byte;
  logic       error;
  logic       byte_done;
  logic       start_receive, slot_we, frame_valid, frame_error, overflow;
  logic [8:0] slot_addr;
  logic [7:0] slot_data, start_code_out;
  logic [9:0] slot_count;

  int checks = 0;
  int failures = 0;

  // Pulse counters and write capture, owned by the monitor
  int n_arm = 0, n_we = 0, n_valid = 0, n_err = 0, n_ovf = 0;
  logic [7:0] wr_mem [0:511];
  logic [8:0] last_addr = '0;

  always #25 clk = ~clk;

  dmx_frame_controller dut (
    .clk             (clk),
    .rst             (rst),
    .DMX_Input_Signal(line),
    .byte_ready      (byte_ready),
    .received_byte   (received_byte),
    .error           (error),
    .byte_done       (byte_done),
    .start_receive   (start_receive),
    .slot_we         (slot_we),
    .slot_addr       (slot_addr),
    .slot_data       (slot_data),
    .start_code_out  (start_code_out),
    .slot_count      (slot_count),
    .frame_valid     (frame_valid),
    .frame_error     (frame_error),
    .overflow        (overflow)
  );

  always @(negedge clk) begin
    if (start_receive) n_arm++;
    if (frame_valid) n_valid++;
    if (frame_error) n_err++;
    if (overflow) n_ovf++;
    if (slot_we) begin
      n_we++;
      wr_mem[slot_addr] = slot_data;
      last_addr = slot_addr;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_break_mab(input int brk, input int mab);
    tick(1);
    line = 1'b0;
    tick(brk);
    line = 1'b1;
    tick(mab);
    line = 1'b0;
    tick(1);
    line = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick(1);
    byte_ready = 1'b1;
    received_byte = b;
    tick(3);
    byte_ready = 1'b0;
    tick(2);
  endtask

  task automatic pulse_done();
    tick(1);
    byte_done = 1'b1;
    tick(1);
    byte_done = 1'b0;
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; line = 1'b1; byte_ready = 1'b0; received_byte = '0;
    error = 1'b0; byte_done = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if ({start_receive, slot_we, slot_addr, slot_data, start_code_out, frame_valid, frame_error, overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%b addr=%0d data=%h sc=%h fv=%b fe=%b ov=%b sr=%b required all 0",
               slot_we, slot_addr, slot_data, start_code_out, frame_valid, frame_error, overflow, start_receive);
    end
    checks++;
    if (slot_count !== 10'd0) begin
      failures++; $display("FAIL reset_slot_count got %0d required 0", slot_count);
    end
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic_frame();
    int a0, w0, v0, e0;
    a0 = n_arm; w0 = n_we; v0 = n_valid; e0 = n_err;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    tick(1);
    byte_ready = 1'b1; received_byte = 8'h11;
    @(negedge clk);
    checks++;
    if (slot_we !== 1'b0) begin
      failures++; $display("FAIL latency_same_cycle slot_we got %b required 0", slot_we);
    end
    @(negedge clk);
    checks++;
    if (slot_we !== 1'b1 || slot_addr !== 9'd0 || slot_data !== 8'h11) begin
      failures++;
      $display("FAIL latency_next_cycle got we=%b addr=%0d data=%h required we=1 addr=0 data=11", slot_we, slot_addr, slot_data);
    end
    tick(3);
    byte_ready = 1'b0;
    tick(2);
    send_byte(8'h22);
    send_byte(8'h33);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_arm - a0 !== 1) begin failures++; $display("FAIL basic_arm got %0d required 1", n_arm - a0); end
    checks++;
    if (n_we - w0 !== 3) begin failures++; $display("FAIL basic_writes got %0d required 3", n_we - w0); end
    checks++;
    if (wr_mem[0] !== 8'h11 || wr_mem[1] !== 8'h22 || wr_mem[2] !== 8'h33) begin
      failures++;
      $display("FAIL basic_data got %h %h %h required 11 22 33", wr_mem[0], wr_mem[1], wr_mem[2]);
    end
    checks++;
    if (slot_count !== 10'd3) begin failures++; $display("FAIL basic_slot_count got %0d required 3", slot_count); end
    checks++;
    if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      failures++; $display("FAIL basic_pulses got valid=%0d err=%0d required 1 0", n_valid - v0, n_err - e0);
    end
  endtask

  task automatic test_short_break();
    int a0, w0, v0, e0, o0;
    a0 = n_arm; w0 = n_we; v0 = n_valid; e0 = n_err; o0 = n_ovf;
    send_break_mab(1200, 240);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h55);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_arm - a0 !== 0 || n_we - w0 !== 0) begin
      failures++; $display("FAIL short_break_arm_we got arm=%0d we=%0d required 0 0", n_arm - a0, n_we - w0);
    end
    checks++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 0 || n_ovf - o0 !== 0) begin
      failures++; $display("FAIL short_break_pulses got v=%0d e=%0d o=%0d required 0 0 0", n_valid - v0, n_err - e0, n_ovf - o0);
    end
  endtask

  task automatic test_other_start_code();
    int w0, v0;
    w0 = n_we; v0 = n_valid;
    send_break_mab(2000, 240);
    send_byte(8'hCC);
    for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i));
    pulse_done();
    @(negedge clk);
    checks++;
    if (start_code_out !== 8'hCC) begin failures++; $display("FAIL cc_start_code got %h required cc", start_code_out); end
    checks++;
    if (slot_count !== 10'd4) begin failures++; $display("FAIL cc_slot_count got %0d required 4", slot_count); end
    checks++;
    if (n_we - w0 !== 0 || n_valid - v0 !== 1) begin
      failures++; $display("FAIL cc_we_valid got we=%0d valid=%0d required 0 1", n_we - w0, n_valid - v0);
    end
  endtask

  task automatic test_framing_error();
    int w0, v0, e0, a0;
    w0 = n_we; v0 = n_valid; e0 = n_err;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    send_byte(8'h5A);
    tick(1);
    error = 1'b1; byte_ready = 1'b1; received_byte = 8'h77;
    tick(3);
    byte_ready = 1'b0;
    tick(2);
    pulse_done();
    error = 1'b0;
    @(negedge clk);
    checks++;
    if (n_we - w0 !== 1 || wr_mem[0] !== 8'h5A) begin
      failures++; $display("FAIL ferr_writes got we=%0d mem0=%h required 1 5a", n_we - w0, wr_mem[0]);
    end
    checks++;
    if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
      failures++; $display("FAIL ferr_pulses got err=%0d valid=%0d required 1 0", n_err - e0, n_valid - v0);
    end
    a0 = n_arm; w0 = n_we; v0 = n_valid;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    send_byte(8'h61);
    send_byte(8'h62);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_arm - a0 !== 1 || n_we - w0 !== 2 || wr_mem[0] !== 8'h61 || wr_mem[1] !== 8'h62) begin
      failures++;
      $display("FAIL ferr_recovery got arm=%0d we=%0d mem=%h %h required 1 2 61 62", n_arm - a0, n_we - w0, wr_mem[0], wr_mem[1]);
    end
    checks++;
    if (n_valid - v0 !== 1 || slot_count !== 10'd2) begin
      failures++; $display("FAIL ferr_recovery_valid got valid=%0d count=%0d required 1 2", n_valid - v0, slot_count);
    end
  endtask

  task automatic test_slot_timeout();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    send_byte(8'h01);
    tick(2100);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
      failures++; $display("FAIL timeout_pulses got err=%0d valid=%0d required 1 0", n_err - e0, n_valid - v0);
    end
  endtask

  task automatic test_overflow();
    int w0, v0, o0;
    w0 = n_we; v0 = n_valid; o0 = n_ovf;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    for (int i = 1; i <= 513; i++) send_byte(8'(i) ^ 8'hA5);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_we - w0 !== 512) begin failures++; $display("FAIL ovf_writes got %0d required 512", n_we - w0); end
    checks++;
    if (last_addr !== 9'd511 || wr_mem[511] !== 8'hA5 || wr_mem[9] !== 8'hAF) begin
      failures++;
      $display("FAIL ovf_last got addr=%0d mem511=%h mem9=%h required 511 a5 af", last_addr, wr_mem[511], wr_mem[9]);
    end
    checks++;
    if (n_ovf - o0 !== 1 || slot_count !== 10'd513 || n_valid - v0 !== 1) begin
      failures++;
      $display("FAIL ovf_pulses got ovf=%0d count=%0d valid=%0d required 1 513 1", n_ovf - o0, slot_count, n_valid - v0);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, e0, o0, w0;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    for (int i = 1; i <= 4; i++) send_byte(8'h40 + 8'(i));
    v0 = n_valid; e0 = n_err; o0 = n_ovf;
    tick(1);
    rst = 1'b1; byte_ready = 1'b1; received_byte = 8'h55;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({slot_we, slot_addr, slot_data, start_code_out, slot_count, frame_valid, frame_error, overflow, start_receive} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got we=%b addr=%0d data=%h count=%0d required all 0", slot_we, slot_addr, slot_data, slot_count);
    end
    tick(2);
    byte_ready = 1'b0;
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    checks++;
    if (n_valid - v0 !== 0 || n_err - e0 !== 0 || n_ovf - o0 !== 0) begin
      failures++; $display("FAIL midreset_pulses got v=%0d e=%0d o=%0d required 0 0 0", n_valid - v0, n_err - e0, n_ovf - o0);
    end
    w0 = n_we; v0 = n_valid;
    send_break_mab(2000, 240);
    send_byte(8'h00);
    send_byte(8'h71);
    send_byte(8'h72);
    send_byte(8'h73);
    pulse_done();
    @(negedge clk);
    checks++;
    if (n_we - w0 !== 3 || wr_mem[0] !== 8'h71 || wr_mem[2] !== 8'h73 || last_addr !== 9'd2) begin
      failures++;
      $display("FAIL midreset_clean got we=%0d mem0=%h mem2=%h last=%0d required 3 71 73 2", n_we - w0, wr_mem[0], wr_mem[2], last_addr);
    end
    checks++;
    if (slot_count !== 10'd3 || n_valid - v0 !== 1) begin
      failures++; $display("FAIL midreset_clean_valid got count=%0d valid=%0d required 3 1", slot_count, n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_break();
    test_other_start_code();
    test_framing_error();
    test_slot_timeout();
    test_overflow();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
